// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter
//   Shares one AXI4 read port between two DMA masters. Master 0 is bsr_dma
//   (STREAM_ID 0) and master 1 is act_dma (STREAM_ID 1). Each master's AR
//   request is captured into a 1-deep pending slot, so a single-cycle arvalid
//   pulse is never lost. Bursts are issued one at a time in round-robin order,
//   and only one burst is outstanding at any time. R beats are routed back to
//   the burst owner. The block checks the beat count and the RID against the
//   issued burst and reports violations on sticky error flags.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   m0_axi_ar*, m1_axi_ar*  master AR channels (arready = pending slot empty)
//   m0_axi_r*,  m1_axi_r*   master R channels; data is broadcast, and rvalid
//                           goes only to the owner
//   s_axi_ar*, s_axi_r*     memory-side AXI4 read port
//   owner                   master that owns the current or last burst
//   busy                    high whenever the FSM is not in IDLE
//   err_len, err_id         sticky errors: rlast misplaced, RID mismatch
//   clr_err                 synchronous clear of both error flags
module dma_rd_arbiter #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4,
    parameter int ID_M0      = 0,
    parameter int ID_M1      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0 (bsr_dma)
    input  logic [AXI_ID_W-1:0]   m0_axi_arid,
    input  logic [AXI_ADDR_W-1:0] m0_axi_araddr,
    input  logic [7:0]            m0_axi_arlen,
    input  logic [2:0]            m0_axi_arsize,
    input  logic [1:0]            m0_axi_arburst,
    input  logic                  m0_axi_arvalid,
    output logic                  m0_axi_arready,
    output logic [AXI_DATA_W-1:0] m0_axi_rdata,
    output logic [1:0]            m0_axi_rresp,
    output logic                  m0_axi_rlast,
    output logic [AXI_ID_W-1:0]   m0_axi_rid,
    output logic                  m0_axi_rvalid,
    input  logic                  m0_axi_rready,
    // master 1 (act_dma)
    input  logic [AXI_ID_W-1:0]   m1_axi_arid,
    input  logic [AXI_ADDR_W-1:0] m1_axi_araddr,
    input  logic [7:0]            m1_axi_arlen,
    input  logic [2:0]            m1_axi_arsize,
    input  logic [1:0]            m1_axi_arburst,
    input  logic                  m1_axi_arvalid,
    output logic                  m1_axi_arready,
    output logic [AXI_DATA_W-1:0] m1_axi_rdata,
    output logic [1:0]            m1_axi_rresp,
    output logic                  m1_axi_rlast,
    output logic [AXI_ID_W-1:0]   m1_axi_rid,
    output logic                  m1_axi_rvalid,
    input  logic                  m1_axi_rready,
    // memory read port
    output logic [AXI_ID_W-1:0]   s_axi_arid,
    output logic [AXI_ADDR_W-1:0] s_axi_araddr,
    output logic [7:0]            s_axi_arlen,
    output logic [2:0]            s_axi_arsize,
    output logic [1:0]            s_axi_arburst,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [AXI_ID_W-1:0]   s_axi_rid,
    input  logic [AXI_DATA_W-1:0] s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rlast,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    // status
    output logic                  owner,
    output logic                  busy,
    output logic                  err_len,
    output logic                  err_id,
    input  logic                  clr_err
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t state, state_nx;

    logic [1:0]                 pending, pending_nx, capture, release_mask;
    logic [1:0][AXI_ID_W-1:0]   slot_id;
    logic [1:0][AXI_ADDR_W-1:0] slot_addr;
    logic [1:0][7:0]            slot_len;
    logic [1:0][2:0]            slot_size;
    logic [1:0][1:0]            slot_burst;

    logic                       last_grant, grant, load_ar;
    logic [7:0]                 expected_len;
    logic [8:0]                 beat_cnt;
    logic                       in_r, ar_hs, r_hs, len_bad, id_bad;
    logic [AXI_ID_W-1:0]        owner_id;

    // A slot accepts a new request only while it is empty.
    assign m0_axi_arready = !pending[0];
    assign m1_axi_arready = !pending[1];
    assign capture        = {m1_axi_arvalid & !pending[1], m0_axi_arvalid & !pending[0]};

    // R routing: data is broadcast, and valid/ready follow the owner only
    // while a burst is in its data phase.
    assign in_r          = (state == R);
    assign s_axi_rready  = in_r && (owner ? m1_axi_rready : m0_axi_rready);
    assign m0_axi_rvalid = in_r && !owner && s_axi_rvalid;
    assign m1_axi_rvalid = in_r &&  owner && s_axi_rvalid;
    assign m0_axi_rdata  = s_axi_rdata;
    assign m0_axi_rresp  = s_axi_rresp;
    assign m0_axi_rlast  = s_axi_rlast;
    assign m0_axi_rid    = s_axi_rid;
    assign m1_axi_rdata  = s_axi_rdata;
    assign m1_axi_rresp  = s_axi_rresp;
    assign m1_axi_rlast  = s_axi_rlast;
    assign m1_axi_rid    = s_axi_rid;

    assign ar_hs    = (state == AR) && s_axi_arready;
    assign r_hs     = s_axi_rvalid && s_axi_rready;
    assign owner_id = owner ? AXI_ID_W'(ID_M1) : AXI_ID_W'(ID_M0);
    // beat_cnt counts the beats already accepted, so the final beat is the
    // one where it equals arlen.
    assign len_bad  = s_axi_rlast != (beat_cnt == {1'b0, expected_len});
    assign id_bad   = s_axi_rid != owner_id;
    assign busy     = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves a value held, and no latch is inferred.
    always_comb begin
        state_nx     = state;
        grant        = 1'b0;
        load_ar      = 1'b0;
        release_mask = 2'b00;
        case (state)
            IDLE: begin
                if (|pending) begin
                    // Both waiting: alternate away from the last winner.
                    grant    = (&pending) ? !last_grant : pending[1];
                    load_ar  = 1'b1;
                    state_nx = AR;
                end
            end
            AR: begin
                if (s_axi_arready) begin
                    release_mask[owner] = 1'b1;
                    state_nx            = R;
                end
            end
            R: begin
                if (r_hs && s_axi_rlast) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // A capture only hits an empty slot, so it never collides with the
        // release of the owner's slot.
        pending_nx = (pending & ~release_mask) | capture;
    end

    // NOTE: state uses non-blocking assignments only, so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= 2'b00;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            expected_len  <= '0;
            beat_cnt      <= '0;
            s_axi_arvalid <= 1'b0;
            s_axi_arid    <= '0;
            s_axi_araddr  <= '0;
            s_axi_arlen   <= '0;
            s_axi_arsize  <= '0;
            s_axi_arburst <= '0;
            err_len       <= 1'b0;
            err_id        <= 1'b0;
            // NOTE: the two request slots are registers, not a RAM, so they
            // are cleared along with the control state. Nothing stale
            // survives a reset.
            slot_id       <= '0;
            slot_addr     <= '0;
            slot_len      <= '0;
            slot_size     <= '0;
            slot_burst    <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;

            if (capture[0]) begin
                slot_id[0]    <= m0_axi_arid;
                slot_addr[0]  <= m0_axi_araddr;
                slot_len[0]   <= m0_axi_arlen;
                slot_size[0]  <= m0_axi_arsize;
                slot_burst[0] <= m0_axi_arburst;
            end
            if (capture[1]) begin
                slot_id[1]    <= m1_axi_arid;
                slot_addr[1]  <= m1_axi_araddr;
                slot_len[1]   <= m1_axi_arlen;
                slot_size[1]  <= m1_axi_arsize;
                slot_burst[1] <= m1_axi_arburst;
            end

            if (load_ar) begin
                owner         <= grant;
                expected_len  <= slot_len[grant];
                s_axi_arid    <= slot_id[grant];
                s_axi_araddr  <= slot_addr[grant];
                s_axi_arlen   <= slot_len[grant];
                s_axi_arsize  <= slot_size[grant];
                s_axi_arburst <= slot_burst[grant];
                s_axi_arvalid <= 1'b1;
            end

            if (ar_hs) begin
                s_axi_arvalid <= 1'b0;
                beat_cnt      <= '0;
            end

            if (r_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
                if (s_axi_rlast) last_grant <= owner;
            end

            // A new error in the same cycle as clr_err wins over the clear.
            if (r_hs && len_bad)  err_len <= 1'b1;
            else if (clr_err)     err_len <= 1'b0;
            if (r_hs && id_bad)   err_id  <= 1'b1;
            else if (clr_err)     err_id  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Self-checking bench for dma_rd_arbiter. The stimulus pushes the expected AR
// issues and R beats into scoreboards. A monitor pops and compares them at
// every memory AR handshake and every master R handshake. A small memory
// model answers AR requests and returns incrementing data (addr + beat).
module tb_dma_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0] m0_axi_arid, m1_axi_arid;
    logic [AW-1:0] m0_axi_araddr, m1_axi_araddr;
    logic [7:0]    m0_axi_arlen, m1_axi_arlen;
    logic [2:0]    m0_axi_arsize, m1_axi_arsize;
    logic [1:0]    m0_axi_arburst, m1_axi_arburst;
    logic          m0_axi_arvalid, m1_axi_arvalid, m0_axi_arready, m1_axi_arready;
    logic [DW-1:0] m0_axi_rdata, m1_axi_rdata;
    logic [1:0]    m0_axi_rresp, m1_axi_rresp;
    logic          m0_axi_rlast, m1_axi_rlast;
    logic [IW-1:0] m0_axi_rid, m1_axi_rid;
    logic          m0_axi_rvalid, m1_axi_rvalid, m0_axi_rready, m1_axi_rready;
    logic [IW-1:0] s_axi_arid, s_axi_rid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst, s_axi_rresp;
    logic          s_axi_arvalid, s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic          owner, busy, err_len, err_id, clr_err;

    dma_rd_arbiter #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .ID_M0(0), .ID_M1(1)) dut (
        .clk(clk), .rst(rst),
        .m0_axi_arid(m0_axi_arid), .m0_axi_araddr(m0_axi_araddr), .m0_axi_arlen(m0_axi_arlen),
        .m0_axi_arsize(m0_axi_arsize), .m0_axi_arburst(m0_axi_arburst),
        .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready),
        .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp), .m0_axi_rlast(m0_axi_rlast),
        .m0_axi_rid(m0_axi_rid), .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready),
        .m1_axi_arid(m1_axi_arid), .m1_axi_araddr(m1_axi_araddr), .m1_axi_arlen(m1_axi_arlen),
        .m1_axi_arsize(m1_axi_arsize), .m1_axi_arburst(m1_axi_arburst),
        .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
        .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rlast(m1_axi_rlast),
        .m1_axi_rid(m1_axi_rid), .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .owner(owner), .busy(busy), .err_len(err_len), .err_id(err_id), .clr_err(clr_err)
    );

    typedef struct packed {
        logic          owner;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } ar_exp_t;

    typedef struct packed {
        logic          m;
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } beat_exp_t;

    ar_exp_t   ar_q[$];
    beat_exp_t beat_q[$];
    int        n_cmp  = 0;
    int        n_fail = 0;

    // memory model state and error injection knobs
    logic          mem_busy = 1'b0;
    logic [AW-1:0] mem_addr;
    int            mem_beat, mem_last_at;
    logic [IW-1:0] mem_rid;
    int            inj_last   = -1;
    logic          inj_rid_en = 1'b0;
    logic [IW-1:0] inj_rid    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Push one burst: the AR issue, then beats 0..last_at carrying addr+i.
    task automatic exp_burst(input logic m, input logic [AW-1:0] addr, input int len,
                             input int last_at, input logic [IW-1:0] rid);
        ar_q.push_back('{owner: m, addr: addr, len: 8'(len), id: (m ? 4'd1 : 4'd0)});
        for (int i = 0; i <= last_at; i++)
            beat_q.push_back('{m: m, data: DW'(addr) + DW'(i), last: (i == last_at), id: rid});
    endtask

    // Entered and left at posedge+1. Waits for the slot to be free, then
    // pulses arvalid for exactly one cycle.
    task automatic req(input logic m, input logic [AW-1:0] addr, input int len);
        int n = 0;
        while (!(m ? m1_axi_arready : m0_axi_arready) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("req_slot_timeout", 64'(n >= 2000), 64'(0));
        if (!m) begin
            m0_axi_arid = 4'd0; m0_axi_araddr = addr; m0_axi_arlen = 8'(len);
            m0_axi_arsize = 3'd3; m0_axi_arburst = 2'd1; m0_axi_arvalid = 1'b1;
        end else begin
            m1_axi_arid = 4'd1; m1_axi_araddr = addr; m1_axi_arlen = 8'(len);
            m1_axi_arsize = 3'd3; m1_axi_arburst = 2'd1; m1_axi_arvalid = 1'b1;
        end
        @(posedge clk); #1;
        if (!m) m0_axi_arvalid = 1'b0;
        else    m1_axi_arvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((ar_q.size() != 0 || beat_q.size() != 0 || busy || mem_busy) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check(name, 64'(n >= 3000), 64'(0));
        @(posedge clk); #1;
    endtask

    // Memory model: it decides at the negedge and drives at posedge+1.
    // arready rises one cycle after arvalid is seen. Beats then stream
    // continuously, subject to rready.
    initial begin : mem_model
        logic nx_arready, nx_rvalid;
        s_axi_arready = 1'b0; s_axi_rvalid = 1'b0; s_axi_rdata = '0;
        s_axi_rlast = 1'b0; s_axi_rid = '0; s_axi_rresp = 2'b00;
        mem_addr = '0; mem_beat = 0; mem_last_at = 0; mem_rid = '0;
        forever begin
            @(negedge clk);
            nx_arready = s_axi_arready;
            nx_rvalid  = s_axi_rvalid;
            if (rst) begin
                mem_busy = 1'b0; nx_arready = 1'b0; nx_rvalid = 1'b0;
                mem_addr = '0; mem_beat = 0; mem_last_at = 0; mem_rid = '0;
            end else if (!mem_busy) begin
                if (s_axi_arvalid && s_axi_arready) begin
                    mem_busy    = 1'b1;
                    mem_addr    = s_axi_araddr;
                    mem_last_at = (inj_last >= 0) ? inj_last : int'(s_axi_arlen);
                    mem_rid     = inj_rid_en ? inj_rid : s_axi_arid;
                    mem_beat    = 0;
                    nx_arready  = 1'b0;
                    nx_rvalid   = 1'b1;
                end else if (s_axi_arvalid) begin
                    nx_arready = 1'b1;
                end
            end else if (s_axi_rvalid && s_axi_rready) begin
                if (mem_beat == mem_last_at) begin
                    mem_busy  = 1'b0;
                    nx_rvalid = 1'b0;
                end else begin
                    mem_beat++;
                end
            end
            @(posedge clk); #1;
            s_axi_arready = nx_arready;
            s_axi_rvalid  = nx_rvalid;
            s_axi_rdata   = DW'(mem_addr) + DW'(mem_beat);
            s_axi_rlast   = (mem_beat == mem_last_at);
            s_axi_rid     = mem_rid;
        end
    end

    task automatic mon_beat(input logic m, input logic [DW-1:0] d, input logic l, input logic [IW-1:0] id);
        beat_exp_t e;
        if (beat_q.size() == 0) begin
            check("r_unexpected_beat", 64'(1), 64'(0));
            return;
        end
        e = beat_q.pop_front();
        check("r_master", 64'(m), 64'(e.m));
        check("r_data", d, e.data);
        check("r_last", 64'(l), 64'(e.last));
        check("r_id", 64'(id), 64'(e.id));
    endtask

    // Monitor: compares at every handshake, independent of the stimulus.
    initial begin : monitor
        ar_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_axi_arvalid && s_axi_arready) begin
                    if (ar_q.size() == 0) begin
                        check("ar_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = ar_q.pop_front();
                        check("ar_owner", 64'(owner), 64'(e.owner));
                        check("ar_addr", 64'(s_axi_araddr), 64'(e.addr));
                        check("ar_len", 64'(s_axi_arlen), 64'(e.len));
                        check("ar_id", 64'(s_axi_arid), 64'(e.id));
                        check("ar_size", 64'(s_axi_arsize), 64'(3));
                        check("ar_after_rlast", 64'(beat_q.size() > 0 && beat_q[0].m != e.owner), 64'(0));
                    end
                end
                if (m0_axi_rvalid && m0_axi_rready)
                    mon_beat(1'b0, m0_axi_rdata, m0_axi_rlast, m0_axi_rid);
                if (m1_axi_rvalid && m1_axi_rready)
                    mon_beat(1'b1, m1_axi_rdata, m1_axi_rlast, m1_axi_rid);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        m0_axi_arvalid = 1'b0; m1_axi_arvalid = 1'b0;
        m0_axi_arid = '0; m0_axi_araddr = '0; m0_axi_arlen = '0; m0_axi_arsize = '0; m0_axi_arburst = '0;
        m1_axi_arid = '0; m1_axi_araddr = '0; m1_axi_arlen = '0; m1_axi_arsize = '0; m1_axi_arburst = '0;
        m0_axi_rready = 1'b1; m1_axi_rready = 1'b1; clr_err = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_arready", 64'(m0_axi_arready), 64'(1));
        check("rst_m1_arready", 64'(m1_axi_arready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_s_arvalid", 64'(s_axi_arvalid), 64'(0));
        check("rst_s_araddr", 64'(s_axi_araddr), 64'(0));
        check("rst_errs", 64'({err_len, err_id}), 64'(0));
        check("rst_s_rready", 64'(s_axi_rready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // simultaneous requests: m0 first (last_grant resets to 1), then m1
        exp_burst(1'b0, 32'h0000_1800, 15, 15, 4'd0);
        exp_burst(1'b1, 32'h0000_1900, 15, 15, 4'd1);
        fork
            req(1'b0, 32'h0000_1800, 15);
            req(1'b1, 32'h0000_1900, 15);
        join
        wait_done("simul_timeout");

        // fairness: both re-request back-to-back, grants alternate 0,1,...
        for (int k = 0; k < 4; k++) begin
            exp_burst(1'b0, 32'h0000_2000 + 32'(k * 256), 1, 1, 4'd0);
            exp_burst(1'b1, 32'h0000_3000 + 32'(k * 256), 1, 1, 4'd1);
        end
        fork
            for (int k = 0; k < 4; k++) req(1'b0, 32'h0000_2000 + 32'(k * 256), 1);
            for (int j = 0; j < 4; j++) req(1'b1, 32'h0000_3000 + 32'(j * 256), 1);
        join
        wait_done("fair_timeout");

        // single m0 burst with latency checks: captured at t, arvalid at t+2
        exp_burst(1'b0, 32'h0000_1000, 3, 3, 4'd0);
        m0_axi_arid = 4'd0; m0_axi_araddr = 32'h0000_1000; m0_axi_arlen = 8'd3;
        m0_axi_arsize = 3'd3; m0_axi_arburst = 2'd1; m0_axi_arvalid = 1'b1;
        @(negedge clk);
        check("lat_t_s_arvalid", 64'(s_axi_arvalid), 64'(0));
        @(posedge clk); #1;
        m0_axi_arvalid = 1'b0;
        @(negedge clk);
        check("lat_t1_m0_arready", 64'(m0_axi_arready), 64'(0));
        check("lat_t1_s_arvalid", 64'(s_axi_arvalid), 64'(0));
        @(negedge clk);
        check("lat_t2_s_arvalid", 64'(s_axi_arvalid), 64'(1));
        check("lat_t2_busy", 64'(busy), 64'(1));
        wait_done("single_timeout");
        check("single_errs", 64'({err_len, err_id}), 64'(0));

        // backpressure: m1 stalls rready for 3 cycles mid-burst
        exp_burst(1'b1, 32'h0000_5000, 7, 7, 4'd1);
        req(1'b1, 32'h0000_5000, 7);
        n = 0;
        while (beat_q.size() > 5 && n < 500) begin @(posedge clk); #1; n++; end
        check("bp_wait_timeout", 64'(n >= 500), 64'(0));
        m1_axi_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_s_rready", 64'(s_axi_rready), 64'(0));
            check("bp_m1_rvalid", 64'(m1_axi_rvalid), 64'(1));
        end
        @(posedge clk); #1;
        m1_axi_rready = 1'b1;
        wait_done("bp_timeout");
        check("bp_errs", 64'({err_len, err_id}), 64'(0));

        // err_len: arlen=3 but rlast arrives on beat 2
        inj_last = 1;
        exp_burst(1'b0, 32'h0000_6000, 3, 1, 4'd0);
        req(1'b0, 32'h0000_6000, 3);
        wait_done("errlen_timeout");
        inj_last = -1;
        check("errlen_set", 64'(err_len), 64'(1));
        check("errlen_no_id", 64'(err_id), 64'(0));
        check("errlen_idle", 64'(busy), 64'(0));

        // err_id: rid=5 returned for an m0 burst
        inj_rid_en = 1'b1; inj_rid = 4'd5;
        exp_burst(1'b0, 32'h0000_6100, 1, 1, 4'd5);
        req(1'b0, 32'h0000_6100, 1);
        wait_done("errid_timeout");
        inj_rid_en = 1'b0;
        check("errid_set", 64'(err_id), 64'(1));
        check("errlen_sticky", 64'(err_len), 64'(1));

        // clr_err: the flags drop after the clock edge that samples it
        clr_err = 1'b1;
        @(negedge clk);
        check("clr_before_edge", 64'({err_len, err_id}), 64'(3));
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("clr_after_edge", 64'({err_len, err_id}), 64'(0));
        @(posedge clk); #1;

        // arlen=0: one beat with rlast is legal
        exp_burst(1'b0, 32'h0000_6200, 0, 0, 4'd0);
        req(1'b0, 32'h0000_6200, 0);
        wait_done("len0_timeout");
        check("len0_errs", 64'({err_len, err_id}), 64'(0));

        // reset during R with m1 pending; afterwards m0 must win first
        exp_burst(1'b0, 32'h0000_7000, 7, 7, 4'd0);
        req(1'b0, 32'h0000_7000, 7);
        req(1'b1, 32'h0000_7100, 3);
        n = 0;
        while (beat_q.size() > 6 && n < 500) begin @(posedge clk); #1; n++; end
        check("rst_wait_timeout", 64'(n >= 500), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_pending", 64'({m1_axi_arready, m0_axi_arready}), 64'(3));
        check("mid_rst_s_arvalid", 64'(s_axi_arvalid), 64'(0));
        check("mid_rst_owner", 64'(owner), 64'(0));
        ar_q.delete();
        beat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_burst(1'b0, 32'h0000_8000, 1, 1, 4'd0);
        exp_burst(1'b1, 32'h0000_8100, 1, 1, 4'd1);
        fork
            req(1'b0, 32'h0000_8000, 1);
            req(1'b1, 32'h0000_8100, 1);
        join
        wait_done("post_rst_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
